// File: rtl/alu_pkg.sv
// Shared ALU package: ALUop encodings, datapath width and the
// sequential multiplier state encoding.
package alu_pkg;

   localparam int unsigned XLEN = 64;

   // ALUop encodings understood by the datapath ALU
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ITER = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/alu64.sv
// Datapath ALU (combinational). The multiplier borrows it for its
// accumulate adds through the EX-stage mux.
// Ports:
//   i_a, i_b    operands
//   i_op        ALUop select (see alu_pkg)
//   o_result_c  combinational result
//   o_zero_c    combinational result == 0
module alu64
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = XLEN
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [3:0]       i_op,
   output logic [WIDTH-1:0] o_result_c,
   output logic             o_zero_c
);

   // Operation select; unknown encodings return 0
   always_comb begin
      o_result_c = '0;
      case (i_op)
         ALU_AND: o_result_c = i_a & i_b;
         ALU_OR:  o_result_c = i_a | i_b;
         ALU_ADD: o_result_c = i_a + i_b;
         ALU_SUB: o_result_c = i_a - i_b;
         ALU_NOR: o_result_c = ~(i_a | i_b);
         default: o_result_c = '0;
      endcase
   end

   assign o_zero_c = (o_result_c == '0);

endmodule

// File: rtl/mul_seq64.sv
// Iterative shift-and-add unsigned multiplier, low WIDTH bits of the
// product. Each ITER cycle issues one ADD to the shared external ALU and
// latches its result as the new accumulator.
// Build option: MUL_SEQ64_EARLY_EXIT_EN -- leave ITER as soon as the
// remaining multiplier bits are all zero (variable latency).
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      operand handshake; in_a multiplicand, in_b multiplier
//   out_valid/out_ready    product handshake; out_p product, out_zero product==0
//   busy                   high in ITER; EX mux hands this block the ALU
//   alu_a/alu_b/alu_op     ALU drive (zero / ADD outside ITER)
//   alu_result/alu_zero    combinational ALU return
module mul_seq64
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH  = XLEN,
   parameter int unsigned CNT_W  = 7,
   parameter logic [3:0]  OP_ADD = ALU_ADD
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_p,
   output logic             out_zero,
   output logic             busy,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [WIDTH-1:0]  r_acc;
   logic [WIDTH-1:0]  r_mcand;
   logic [WIDTH-1:0]  r_mplier;
   logic [CNT_W-1:0]  r_cnt;
   logic [WIDTH-1:0]  r_out_p;
   logic              r_out_zero;
   logic              r_out_valid;
   logic              w_last;
   logic              w_accept;

   // Last iteration: fixed count, or optionally no multiplier bits left
`ifdef MUL_SEQ64_EARLY_EXIT_EN
   assign w_last = (r_cnt == CNT_W'(WIDTH - 1)) || ((r_mplier >> 1) == '0);
`else
   assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
`endif

   assign w_accept = in_valid && (r_state == IDLE);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state and ALU / handshake drive
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      busy        = 1'b0;
      alu_a       = '0;
      alu_b       = '0;
      alu_op      = OP_ADD;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = ITER;
         end
         ITER: begin
            busy  = 1'b1;
            alu_a = r_acc;
            alu_b = r_mplier[0] ? r_mcand : '0;
            if (w_last) w_state_nxt = DONE;
         end
         DONE: begin
            if (r_out_valid && out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Shift/accumulate datapath and product register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc       <= '0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_cnt       <= '0;
         r_out_p     <= '0;
         r_out_zero  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_acc    <= '0;
                  r_mcand  <= in_a;
                  r_mplier <= in_b;
                  r_cnt    <= '0;
               end
            end
            ITER: begin
               r_acc    <= alu_result;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + CNT_W'(1);
               // Final sum goes straight from the ALU to the product register
               if (w_last) begin
                  r_out_p     <= alu_result;
                  r_out_zero  <= alu_zero;
                  r_out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (r_out_valid && out_ready) r_out_valid <= 1'b0;
            end
            default: r_out_valid <= 1'b0;
         endcase
      end
   end

   assign out_p     = r_out_p;
   assign out_zero  = r_out_zero;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mul_seq64.sv
// Directed bench for mul_seq64 driving the real datapath ALU.
module tb_mul_seq64;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_a;
   logic [63:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_p;
   logic        out_zero;
   logic        busy;
   logic [63:0] alu_a;
   logic [63:0] alu_b;
   logic [3:0]  alu_op;
   logic [63:0] alu_result;
   logic        alu_zero;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

`ifdef MUL_SEQ64_EARLY_EXIT_EN
   localparam int RST_IT = 2;
`else
   localparam int RST_IT = 20;
`endif

   mul_seq64 u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_p      (out_p),
      .out_zero   (out_zero),
      .busy       (busy),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .alu_zero   (alu_zero)
   );

   alu64 u_alu (
      .i_a        (alu_a),
      .i_b        (alu_b),
      .i_op       (alu_op),
      .o_result_c (alu_result),
      .o_zero_c   (alu_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected iteration count for a given multiplier
   function automatic int exp_lat(input logic [63:0] b);
`ifdef MUL_SEQ64_EARLY_EXIT_EN
      int h = 0;
      for (int i = 0; i < 64; i++) if (b[i]) h = i;
      return h + 1;
`else
      return 64;
`endif
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},  64'(in_ready), 64'd1);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_out_p"},     out_p, 64'd0);
      check({tag, "_out_zero"},  64'(out_zero), 64'd0);
      check({tag, "_busy"},      64'(busy), 64'd0);
      check({tag, "_alu_a"},     alu_a, 64'd0);
      check({tag, "_alu_b"},     alu_b, 64'd0);
      check({tag, "_alu_op"},    64'(alu_op), 64'd2);
   endtask

   // Called #1 after an edge with the DUT idle; returns #1 after the
   // edge on which the product was consumed.
   task automatic do_mul(input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] p, input int hold, input string tag);
      int   lat;
      int   nbusy;
      logic op_ok;
      check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      out_ready = (hold == 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a     = ~a;
      in_b     = ~b;
      lat   = 0;
      nbusy = 0;
      op_ok = 1'b1;
      while (!out_valid && lat < 200) begin
         if (busy) begin
            nbusy++;
            if (alu_op !== 4'b0010) op_ok = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat(b)));
      check({tag, "_busy_cycles"}, 64'(nbusy), 64'(exp_lat(b)));
      check({tag, "_alu_op_add"}, 64'(op_ok), 64'd1);
      check({tag, "_out_p"}, out_p, p);
      check({tag, "_out_zero"}, 64'(out_zero), 64'(p == 64'd0));
      check({tag, "_done_busy"}, 64'(busy), 64'd0);
      check({tag, "_done_in_ready"}, 64'(in_ready), 64'd0);
      if (hold > 0) begin
         // A new request during the stall must be ignored
         in_valid = 1'b1;
         in_a     = 64'd11;
         in_b     = 64'd13;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_p"}, out_p, p);
            check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      check({tag, "_consumed_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_consumed_in_ready"}, 64'(in_ready), 64'd1);
      check({tag, "_consumed_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;
      #12;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_mul(64'd3, 64'd5, 64'd15, 0, "3x5");
      do_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0, "wrap");
      do_mul(64'h1234, 64'd0, 64'd0, 0, "b_zero");
      do_mul(64'd0, 64'd77, 64'd0, 0, "a_zero");
      do_mul(64'd6, 64'd7, 64'd42, 10, "stall");

      // Reset in the middle of 7*9
      in_valid = 1'b1;
      in_a     = 64'd7;
      in_b     = 64'd9;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < RST_IT; i++) begin
         @(posedge clk); #1;
      end
      check("midrst_busy_before", 64'(busy), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(posedge clk); #1;
      check("midrst_held_valid", 64'(out_valid), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_mul(64'd7, 64'd9, 64'd63, 0, "7x9_after_rst");

      // Back-to-back
      do_mul(64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 0, "b2b_zero");
      do_mul(64'hFFFF, 64'hFFFF, 64'hFFFE_0001, 0, "b2b_ffff");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
